// File: rtl/vpu_tile_sequencer_if.sv
// ---------------------------------------------------------------------------
// vpu_tile_sequencer_if
//   Bundles the job/config inputs, the memory beat strobes and the compute
//   core handshake of the tile sequencer.
//
//   Memory beat handshake: a strobe (load_a / load_w / deload_out) is the
//   valid and mem_ready is the ready. A beat transfers on a rising clock
//   edge where strobe & mem_ready. While the strobe is high and mem_ready
//   is low, the strobe and its address are held unchanged. The strobe never
//   drops without a transfer, except on abort or reset.
//
//   Modports:
//     master : the sequencer (drives strobes, addresses, status)
//     slave  : the environment (RAM, compute core, job issuer)
//
//   Signals:
//     start, abort                 job request / synchronous cancel
//     m_tiles, k_tiles, n_tiles    tile counts, latched at start
//     base_a, base_w, base_res     base word addresses, latched at start
//     mem_ready                    RAM accepts the current beat
//     compute_done                 core finished the current tile MAC
//     load_a, load_w, deload_out   beat strobes
//     addr_a, addr_w, addr_res     beat addresses
//     compute_start, acc_clr       compute pulse / accumulator clear
//     index_i, index_j, index_k    live tile indices
//     busy, done, aborted          job status
//     state_dbg                    current FSM state encoding
// ---------------------------------------------------------------------------
interface vpu_tile_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DIM_WIDTH  = 8
);
   logic                  start;
   logic                  abort;
   logic [DIM_WIDTH-1:0]  m_tiles;
   logic [DIM_WIDTH-1:0]  k_tiles;
   logic [DIM_WIDTH-1:0]  n_tiles;
   logic [ADDR_WIDTH-1:0] base_a;
   logic [ADDR_WIDTH-1:0] base_w;
   logic [ADDR_WIDTH-1:0] base_res;
   logic                  mem_ready;
   logic                  compute_done;

   logic                  load_a;
   logic                  load_w;
   logic                  deload_out;
   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_w;
   logic [ADDR_WIDTH-1:0] addr_res;
   logic                  compute_start;
   logic                  acc_clr;
   logic [DIM_WIDTH-1:0]  index_i;
   logic [DIM_WIDTH-1:0]  index_j;
   logic [DIM_WIDTH-1:0]  index_k;
   logic                  busy;
   logic                  done;
   logic                  aborted;
   logic [2:0]            state_dbg;

   modport master (
      input  start, abort, m_tiles, k_tiles, n_tiles,
      input  base_a, base_w, base_res, mem_ready, compute_done,
      output load_a, load_w, deload_out, addr_a, addr_w, addr_res,
      output compute_start, acc_clr, index_i, index_j, index_k,
      output busy, done, aborted, state_dbg
   );

   modport slave (
      output start, abort, m_tiles, k_tiles, n_tiles,
      output base_a, base_w, base_res, mem_ready, compute_done,
      input  load_a, load_w, deload_out, addr_a, addr_w, addr_res,
      input  compute_start, acc_clr, index_i, index_j, index_k,
      input  busy, done, aborted, state_dbg
   );
endinterface

// File: rtl/vpu_tile_sequencer.sv
// ---------------------------------------------------------------------------
// vpu_tile_sequencer
//   Tile-loop controller for the tiled vector matrix-multiply unit. Walks a
//   runtime-sized C = A x W job as TILE x TILE tiles: for every C tile (i,j)
//   and every inner step k it streams TILE rows of A(i,k) and W(k,j) from
//   RAM, pulses the compute core, waits for it, and after the last k streams
//   the C(i,j) tile back to RAM.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    vpu_tile_sequencer_if.master (config, beats, compute, status)
//
//   Loop order is i (outer), j, k (inner). Dimensions and bases are latched
//   when a job starts; config inputs are ignored while busy.
// ---------------------------------------------------------------------------
module vpu_tile_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int TILE       = 4,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   vpu_tile_sequencer_if.master bus
);

   localparam int RW = $clog2(TILE);
   localparam logic [RW-1:0] R_LAST = RW'(TILE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_W = 3'd2,
      S_CSTART = 3'd3,
      S_CWAIT  = 3'd4,
      S_STORE  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [DIM_WIDTH-1:0]  i_q, i_d;
   logic [DIM_WIDTH-1:0]  j_q, j_d;
   logic [DIM_WIDTH-1:0]  k_q, k_d;
   logic [RW-1:0]         r_q, r_d;
   logic [DIM_WIDTH-1:0]  m_q, m_d;
   logic [DIM_WIDTH-1:0]  kt_q, kt_d;
   logic [DIM_WIDTH-1:0]  n_q, n_d;
   logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
   logic [ADDR_WIDTH-1:0] base_w_q, base_w_d;
   logic [ADDR_WIDTH-1:0] base_res_q, base_res_d;
   logic                  aborted_q, aborted_d;

   logic                  row_last;
   logic                  k_last;
   logic                  j_last;
   logic                  i_last;

   assign row_last = (r_q == R_LAST);
   assign k_last   = (k_q == kt_q - DIM_WIDTH'(1));
   assign j_last   = (j_q == n_q - DIM_WIDTH'(1));
   assign i_last   = (i_q == m_q - DIM_WIDTH'(1));

   // -------------------------------------------------------------------------
   // State and counter registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         r_q        <= '0;
         m_q        <= '0;
         kt_q       <= '0;
         n_q        <= '0;
         base_a_q   <= '0;
         base_w_q   <= '0;
         base_res_q <= '0;
         aborted_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         k_q        <= k_d;
         r_q        <= r_d;
         m_q        <= m_d;
         kt_q       <= kt_d;
         n_q        <= n_d;
         base_a_q   <= base_a_d;
         base_w_q   <= base_w_d;
         base_res_q <= base_res_d;
         aborted_q  <= aborted_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      k_d        = k_q;
      r_d        = r_q;
      m_d        = m_q;
      kt_d       = kt_q;
      n_d        = n_q;
      base_a_d   = base_a_q;
      base_w_d   = base_w_q;
      base_res_d = base_res_q;
      aborted_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               m_d        = bus.m_tiles;
               kt_d       = bus.k_tiles;
               n_d        = bus.n_tiles;
               base_a_d   = bus.base_a;
               base_w_d   = bus.base_w;
               base_res_d = bus.base_res;
               i_d        = '0;
               j_d        = '0;
               k_d        = '0;
               r_d        = '0;
               // An empty problem completes without touching memory.
               if (bus.m_tiles == '0 || bus.k_tiles == '0 || bus.n_tiles == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD_A;
               end
            end
         end

         S_LOAD_A: begin
            if (bus.mem_ready) begin
               if (row_last) begin
                  r_d     = '0;
                  state_d = S_LOAD_W;
               end else begin
                  r_d = r_q + RW'(1);
               end
            end
         end

         S_LOAD_W: begin
            if (bus.mem_ready) begin
               if (row_last) begin
                  r_d     = '0;
                  state_d = S_CSTART;
               end else begin
                  r_d = r_q + RW'(1);
               end
            end
         end

         S_CSTART: begin
            state_d = S_CWAIT;
         end

         S_CWAIT: begin
            if (bus.compute_done) begin
               if (k_last) begin
                  k_d     = '0;
                  state_d = S_STORE;
               end else begin
                  k_d     = k_q + DIM_WIDTH'(1);
                  state_d = S_LOAD_A;
               end
            end
         end

         S_STORE: begin
            if (bus.mem_ready) begin
               if (row_last) begin
                  r_d = '0;
                  if (!j_last) begin
                     j_d     = j_q + DIM_WIDTH'(1);
                     state_d = S_LOAD_A;
                  end else begin
                     j_d = '0;
                     if (!i_last) begin
                        i_d     = i_q + DIM_WIDTH'(1);
                        state_d = S_LOAD_A;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
               end else begin
                  r_d = r_q + RW'(1);
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides whatever the state wanted to do. Indices are left as
      // they were; the next start clears them.
      if (bus.abort && state_q != S_IDLE) begin
         state_d   = S_IDLE;
         r_d       = '0;
         aborted_d = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Beat addresses: row-major, one word per TILE-wide row segment.
   //   A: base_a   + (i*TILE + r)*k_tiles + k
   //   W: base_w   + (k*TILE + r)*n_tiles + j
   //   C: base_res + (i*TILE + r)*n_tiles + j
   // Everything is computed modulo 2^ADDR_WIDTH. Addresses read 0 whenever
   // their strobe is low.
   // -------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] row_i;
   logic [ADDR_WIDTH-1:0] row_k;
   logic [ADDR_WIDTH-1:0] off_a;
   logic [ADDR_WIDTH-1:0] off_w;
   logic [ADDR_WIDTH-1:0] off_c;
   logic                  load_a;
   logic                  load_w;
   logic                  deload;

   assign row_i = (ADDR_WIDTH'(i_q) << RW) + ADDR_WIDTH'(r_q);
   assign row_k = (ADDR_WIDTH'(k_q) << RW) + ADDR_WIDTH'(r_q);
   assign off_a = row_i * ADDR_WIDTH'(kt_q) + ADDR_WIDTH'(k_q);
   assign off_w = row_k * ADDR_WIDTH'(n_q) + ADDR_WIDTH'(j_q);
   assign off_c = row_i * ADDR_WIDTH'(n_q) + ADDR_WIDTH'(j_q);

   assign load_a = (state_q == S_LOAD_A);
   assign load_w = (state_q == S_LOAD_W);
   assign deload = (state_q == S_STORE);

   // -------------------------------------------------------------------------
   // Outputs (all decoded from registered state, none from inputs)
   // -------------------------------------------------------------------------
   assign bus.load_a        = load_a;
   assign bus.load_w        = load_w;
   assign bus.deload_out    = deload;
   assign bus.addr_a        = load_a ? (base_a_q + off_a) : '0;
   assign bus.addr_w        = load_w ? (base_w_q + off_w) : '0;
   assign bus.addr_res      = deload ? (base_res_q + off_c) : '0;
   assign bus.compute_start = (state_q == S_CSTART);
   assign bus.acc_clr       = (state_q == S_CSTART) && (k_q == '0);
   assign bus.index_i       = i_q;
   assign bus.index_j       = j_q;
   assign bus.index_k       = k_q;
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = (state_q == S_DONE);
   assign bus.aborted       = aborted_q;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_vpu_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vpu_tile_sequencer
//   Directed bench for vpu_tile_sequencer with TILE = 4. Intervals are
//   numbered relative to the clock edge that samples start (edge 0): the
//   interval ending at edge n is "cycle n". The negedge process drives the
//   RAM/core side (mem_ready stalls, compute_done D cycles after
//   compute_start, abort) and logs every completed beat with its cycle.
// ---------------------------------------------------------------------------
module tb_vpu_tile_sequencer;

   localparam int AW   = 16;
   localparam int DW   = 8;
   localparam int TILE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vpu_tile_sequencer_if #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW)) bus ();

   vpu_tile_sequencer #(
      .ADDR_WIDTH (AW),
      .TILE       (TILE),
      .DIM_WIDTH  (DW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] a_q[$];
   logic [AW-1:0] w_q[$];
   logic [AW-1:0] c_q[$];
   logic [AW-1:0] stall_q[$];
   int            a_cyc[$];
   int            w_cyc[$];
   int            c_cyc[$];

   bit job_active = 1'b0;
   int t0, rel;
   int d_cfg, slo, shi, ab_at, rst_at, cd_at;
   int cs_cnt, clr_cnt, clr_stray, cs_rel;
   int done_cnt, done_rel, ab_cnt, ab_rel, post_ab_strobes;
   logic ab_busy;
   bit rst_seen;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic any_out();
      return |{bus.load_a, bus.load_w, bus.deload_out, bus.addr_a, bus.addr_w,
               bus.addr_res, bus.compute_start, bus.acc_clr, bus.index_i,
               bus.index_j, bus.index_k, bus.busy, bus.done, bus.aborted};
   endfunction

   // Compare one logged beat stream (0 = A, 1 = W, 2 = C) against exp_q.
   task automatic compare_beats(input string tag, input int which);
      logic [AW-1:0] obs[$];
      case (which)
         0:       obs = a_q;
         1:       obs = w_q;
         default: obs = c_q;
      endcase
      check_eq({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
      for (int idx = 0; idx < exp_q.size(); idx++) begin
         if (idx < obs.size())
            check_eq($sformatf("%s[%0d]", tag, idx), 32'(obs[idx]), 32'(exp_q[idx]));
      end
      exp_q.delete();
   endtask

   // ---------------- environment + monitor ----------------
   always @(negedge clk) begin
      if (job_active) begin
         rel              = cyc - t0 + 1;
         bus.mem_ready    = !(rel >= slo && rel <= shi);
         bus.compute_done = (rel == cd_at);
         bus.abort        = (rel == ab_at);
         if (bus.load_a && bus.mem_ready) begin
            a_q.push_back(bus.addr_a);
            a_cyc.push_back(rel);
         end
         if (bus.load_w) begin
            if (bus.mem_ready) begin
               w_q.push_back(bus.addr_w);
               w_cyc.push_back(rel);
            end else begin
               stall_q.push_back(bus.addr_w);
            end
         end
         if (bus.deload_out && bus.mem_ready) begin
            c_q.push_back(bus.addr_res);
            c_cyc.push_back(rel);
         end
         if (bus.compute_start) begin
            cs_cnt++;
            cs_rel = rel;
            cd_at  = rel + d_cfg;
            if (bus.acc_clr) clr_cnt++;
         end else if (bus.acc_clr) begin
            clr_stray++;
         end
         if (bus.done) begin
            done_cnt++;
            done_rel = rel;
         end
         if (bus.aborted) begin
            ab_cnt++;
            ab_rel  = rel;
            ab_busy = bus.busy;
         end
         if (ab_at != 0 && rel > ab_at && (bus.load_a || bus.load_w || bus.deload_out))
            post_ab_strobes++;
      end else begin
         bus.mem_ready    = 1'b1;
         bus.compute_done = 1'b0;
         bus.abort        = 1'b0;
      end
   end

   // ---------------- driver ----------------
   task automatic run_job(input int m, input int k, input int n,
                          input int ba, input int bw, input int br,
                          input int d, input int s_lo, input int s_hi,
                          input int abat, input int rstat);
      bit ended;
      a_q.delete(); w_q.delete(); c_q.delete(); stall_q.delete();
      a_cyc.delete(); w_cyc.delete(); c_cyc.delete();
      cs_cnt = 0; clr_cnt = 0; clr_stray = 0; cs_rel = 0;
      done_cnt = 0; done_rel = 0; ab_cnt = 0; ab_rel = 0; ab_busy = 1'b0;
      post_ab_strobes = 0; rst_seen = 1'b0; ended = 1'b0;
      d_cfg = d; slo = s_lo; shi = s_hi; ab_at = abat; rst_at = rstat;
      cd_at = 1000000;

      @(posedge clk); #1;
      bus.m_tiles  = DW'(m);
      bus.k_tiles  = DW'(k);
      bus.n_tiles  = DW'(n);
      bus.base_a   = AW'(ba);
      bus.base_w   = AW'(bw);
      bus.base_res = AW'(br);
      bus.start    = 1'b1;
      @(posedge clk); #1;
      t0         = cyc;
      bus.start  = 1'b0;
      job_active = 1'b1;
      // Config must be ignored once the job is running.
      bus.m_tiles  = DW'($urandom_range(1, 255));
      bus.k_tiles  = DW'($urandom_range(1, 255));
      bus.n_tiles  = DW'($urandom_range(1, 255));
      bus.base_a   = AW'($urandom_range(0, 65535));
      bus.base_w   = AW'($urandom_range(0, 65535));
      bus.base_res = AW'($urandom_range(0, 65535));

      for (int c = 0; c < 400; c++) begin
         @(negedge clk); #1;
         if (rst_at != 0 && rel == rst_at) begin
            reset = 1'b0;
            #1;
            check_eq("rst_async_outputs", {31'd0, any_out()}, 32'd0);
            check_eq("rst_async_state", 32'(bus.state_dbg), 32'd0);
            rst_seen = 1'b1;
         end
         if (done_cnt > 0 || ab_cnt > 0 || rst_seen) begin
            ended = 1'b1;
            break;
         end
      end
      check_eq("job_terminated", {31'd0, ended}, 32'd1);
      repeat (3) @(negedge clk);
      #1;
      job_active = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.m_tiles  = '0;
      bus.k_tiles  = '0;
      bus.n_tiles  = '0;
      bus.base_a   = '0;
      bus.base_w   = '0;
      bus.base_res = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_outputs", {31'd0, any_out()}, 32'd0);
      check_eq("reset_state", 32'(bus.state_dbg), 32'd0);
      reset = 1'b1;
      @(posedge clk);

      // 1) single tile, compute_done two cycles after compute_start
      run_job(1, 1, 1, 'h10, 'h20, 'h30, 2, 0, -1, 0, 0);
      exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
      compare_beats("t1_a", 0);
      exp_q = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
      compare_beats("t1_w", 1);
      exp_q = '{16'h0030, 16'h0031, 16'h0032, 16'h0033};
      compare_beats("t1_c", 2);
      check_eq("t1_a_first_cyc", 32'(a_cyc[0]), 32'd1);
      check_eq("t1_a_last_cyc", 32'(a_cyc[3]), 32'd4);
      check_eq("t1_w_first_cyc", 32'(w_cyc[0]), 32'd5);
      check_eq("t1_cstart_cyc", 32'(cs_rel), 32'd9);
      check_eq("t1_acc_clr", 32'(clr_cnt), 32'd1);
      check_eq("t1_c_first_cyc", 32'(c_cyc[0]), 32'd12);
      check_eq("t1_c_last_cyc", 32'(c_cyc[3]), 32'd15);
      check_eq("t1_done_cyc", 32'(done_rel), 32'd16);
      check_eq("t1_done_count", 32'(done_cnt), 32'd1);

      // 2) 2x2x2 tiles
      run_job(2, 2, 2, 'h0, 'h40, 'h100, 2, 0, -1, 0, 0);
      check_eq("t2_compute_starts", 32'(cs_cnt), 32'd8);
      check_eq("t2_acc_clr", 32'(clr_cnt), 32'd4);
      check_eq("t2_acc_clr_stray", 32'(clr_stray), 32'd0);
      check_eq("t2_a_beats", 32'(a_q.size()), 32'd32);
      check_eq("t2_c_beats", 32'(c_q.size()), 32'd16);
      check_eq("t2_a_i1k1_r0", 32'(a_q[20]), 32'd9);
      check_eq("t2_a_i1k1_r1", 32'(a_q[21]), 32'd11);
      check_eq("t2_a_i1k1_r2", 32'(a_q[22]), 32'd13);
      check_eq("t2_a_i1k1_r3", 32'(a_q[23]), 32'd15);
      check_eq("t2_w_k1j0_r0", 32'(w_q[4]), 32'h48);
      check_eq("t2_w_k1j0_r3", 32'(w_q[7]), 32'h4e);
      check_eq("t2_c_i1j1_r0", 32'(c_q[12]), 32'h109);
      check_eq("t2_c_i1j1_r3", 32'(c_q[15]), 32'h10f);
      check_eq("t2_done_count", 32'(done_cnt), 32'd1);
      check_eq("t2_done_cyc", 32'(done_rel), 32'd105);
      check_eq("t2_index_i_hold", 32'(bus.index_i), 32'd1);
      check_eq("t2_index_j_hold", 32'(bus.index_j), 32'd0);
      check_eq("t2_index_k_hold", 32'(bus.index_k), 32'd0);

      // 3) mem_ready low for cycles 6-8, inside LOAD_W
      run_job(1, 1, 1, 'h10, 'h20, 'h30, 2, 6, 8, 0, 0);
      exp_q = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
      compare_beats("t3_w", 1);
      check_eq("t3_stall_cycles", 32'(stall_q.size()), 32'd3);
      check_eq("t3_stall_addr0", 32'(stall_q[0]), 32'h21);
      check_eq("t3_stall_addr2", 32'(stall_q[2]), 32'h21);
      check_eq("t3_w_last_cyc", 32'(w_cyc[3]), 32'd11);
      check_eq("t3_cstart_cyc", 32'(cs_rel), 32'd12);
      check_eq("t3_done_cyc", 32'(done_rel), 32'd19);

      // 4) zero inner dimension
      run_job(1, 0, 1, 'h10, 'h20, 'h30, 2, 0, -1, 0, 0);
      check_eq("t4_beats", 32'(a_q.size() + w_q.size() + c_q.size()), 32'd0);
      check_eq("t4_compute_starts", 32'(cs_cnt), 32'd0);
      check_eq("t4_done_cyc", 32'(done_rel), 32'd1);
      check_eq("t4_done_count", 32'(done_cnt), 32'd1);

      // 5) abort while waiting for the core, then a clean rerun
      run_job(1, 1, 1, 'h10, 'h20, 'h30, 30, 0, -1, 11, 0);
      check_eq("t5_aborted_cyc", 32'(ab_rel), 32'd12);
      check_eq("t5_aborted_count", 32'(ab_cnt), 32'd1);
      check_eq("t5_busy_at_abort", {31'd0, ab_busy}, 32'd0);
      check_eq("t5_no_done", 32'(done_cnt), 32'd0);
      check_eq("t5_strobes_after", 32'(post_ab_strobes), 32'd0);

      run_job(1, 1, 1, 'h10, 'h20, 'h30, 2, 0, -1, 0, 0);
      exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
      compare_beats("t5b_a", 0);
      exp_q = '{16'h0030, 16'h0031, 16'h0032, 16'h0033};
      compare_beats("t5b_c", 2);
      check_eq("t5b_done_cyc", 32'(done_rel), 32'd16);

      // 6) reset mid-STORE, then a job whose C rows wrap the address space
      run_job(1, 1, 1, 'h10, 'h20, 'h30, 2, 0, -1, 0, 13);
      check_eq("t6_no_done", 32'(done_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      run_job(1, 1, 1, 'h10, 'h20, 'hfffe, 2, 0, -1, 0, 0);
      exp_q = '{16'hfffe, 16'hffff, 16'h0000, 16'h0001};
      compare_beats("t6b_c", 2);
      check_eq("t6b_done_cyc", 32'(done_rel), 32'd16);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
